// File: rtl/bidir_link_ctrl_if.sv
// Link-side signal bundle for one bidirectional-channel direction controller.
// Latency: none; this is wiring only.
// Backpressure: carried by the req/rel handshake and local_busy inside the bundle.
interface bidir_link_ctrl_if;
   logic local_req;
   logic local_busy;
   logic req_in;
   logic rel_in;
   logic req_out;
   logic rel_out;
   logic dir_out;
   logic own;
   logic proto_err;

   // Controller side: consumes local status and neighbour handshake, produces direction.
   modport slave (
      input  local_req, local_busy, req_in, rel_in,
      output req_out, rel_out, dir_out, own, proto_err
   );

   // Router/environment side.
   modport master (
      output local_req, local_busy, req_in, rel_in,
      input  req_out, rel_out, dir_out, own, proto_err
   );
endinterface

// File: rtl/bidir_link_ctrl.sv
// Direction controller for one end of a bidirectional inter-router channel (optional macro HOLD_TIMEOUT_EN).
// Latency: release decision in cycle N -> dir_out low N+1, rel_out pulse N+1+TURN_CYC; rel_in -> ownership next cycle.
// Backpressure: the owner yields only at packet boundaries; HOLD_TIMEOUT_EN forces a yield after MAX_HOLD owned cycles.
module bidir_link_ctrl #(
   parameter bit IS_HP    = 1'b1,
   parameter int TURN_CYC = 2,
   parameter int IDLE_CYC = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   bidir_link_ctrl_if.slave lnk
);

   typedef enum logic [1:0] {
      ST_OWN   = 2'd0,
      ST_TURN  = 2'd1,
      ST_NOOWN = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   localparam logic [3:0] IDLE_MAX  = 4'(IDLE_CYC);
   localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);
   localparam state_t     ST_RESET  = IS_HP ? ST_OWN : ST_NOOWN;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] idle_cnt;
   logic [3:0] turn_cnt;
   logic       req_in_q;
   logic       hold_expired;

   logic       dir_q, own_q, req_q, rel_q, err_q;
   logic       dir_nxt, own_nxt, req_nxt, rel_nxt, err_nxt;

   logic       idle_now;
   logic       stay_own;

   assign idle_now = !lnk.local_req && !lnk.local_busy;
   assign stay_own = (state == ST_OWN) && (state_nxt == ST_OWN);

`ifdef HOLD_TIMEOUT_EN
   localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);
   logic [4:0] hold_cnt;

   // Ownership age: zero on entry to OWN, counts every owned cycle, saturates at MAX_HOLD
   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_cnt <= '0;
      end else if (stay_own) begin
         hold_cnt <= (hold_cnt >= HOLD_MAX) ? hold_cnt : hold_cnt + 5'd1;
      end else begin
         hold_cnt <= '0;
      end
   end

   assign hold_expired = (hold_cnt >= HOLD_MAX);
`else
   logic unused_hold_cfg;
   assign unused_hold_cfg = |5'(MAX_HOLD);
   assign hold_expired    = 1'b0;
`endif

   // State and registered outputs; the neighbour's request is flopped once on arrival
   // so every release decision works from a local register rather than a cross-router wire
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= ST_RESET;
         req_in_q <= 1'b0;
         dir_q    <= IS_HP;
         own_q    <= IS_HP;
         req_q    <= 1'b0;
         rel_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         req_in_q <= lnk.req_in;
         dir_q    <= dir_nxt;
         own_q    <= own_nxt;
         req_q    <= req_nxt;
         rel_q    <= rel_nxt;
         err_q    <= err_nxt;
      end
   end

   // Idle-run and turnaround counters; both clear whenever their state run is broken
   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         if (stay_own && idle_now) begin
            idle_cnt <= (idle_cnt >= IDLE_MAX) ? idle_cnt : idle_cnt + 4'd1;
         end else begin
            idle_cnt <= '0;
         end
         if ((state == ST_TURN) && (state_nxt == ST_TURN)) begin
            turn_cnt <= turn_cnt + 4'd1;
         end else begin
            turn_cnt <= '0;
         end
      end
   end

   // Next state: release only between packets, turnaround is committed once started,
   // and a grant arriving with a request withdrawal still hands over ownership
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_OWN: begin
            if (req_in_q && !lnk.local_busy && ((idle_cnt >= IDLE_MAX) || hold_expired)) begin
               state_nxt = ST_TURN;
            end
         end
         ST_TURN: begin
            if (turn_cnt == TURN_LAST) begin
               state_nxt = ST_NOOWN;
            end
         end
         ST_NOOWN: begin
            if (lnk.local_req) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lnk.rel_in) begin
               state_nxt = ST_OWN;
            end else if (!lnk.local_req) begin
               state_nxt = ST_NOOWN;
            end
         end
         default: state_nxt = ST_RESET;
      endcase
   end

   // Output values for the next cycle, derived from the transition being taken
   always_comb begin
      dir_nxt = (state_nxt == ST_OWN);
      own_nxt = (state_nxt == ST_OWN);
      req_nxt = (state_nxt == ST_WAIT);
      rel_nxt = (state == ST_TURN) && (state_nxt == ST_NOOWN);
      err_nxt = err_q
              | (lnk.rel_in && (state != ST_WAIT))
              | (lnk.local_busy && (state != ST_OWN));
   end

   assign lnk.dir_out   = dir_q;
   assign lnk.own       = own_q;
   assign lnk.req_out   = req_q;
   assign lnk.rel_out   = rel_q;
   assign lnk.proto_err = err_q;

endmodule
